// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART transmit feeder.
package uart_pkg;

    localparam int DEPTH_DEFAULT         = 16;
    localparam int START_TIMEOUT_DEFAULT = 4096;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered occupancy flags and a one-cycle overflow pulse.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          wr_ok_s, rd_ok_s;

    // Next-state for pointers, occupancy and flags; full_q gates writes even when a pop happens.
    always_comb begin
        wr_ok_s = wr_en && !full_q;
        rd_ok_s = rd_en && !empty_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d    = count_q + CW'(wr_ok_s) - CW'(rd_ok_s);
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == {CW{1'b0}});
        overflow_d = wr_en && full_q;
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Byte storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains a byte FIFO into a UART transmitter with start timeout and sent-byte counting.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEFAULT,
    parameter int START_TIMEOUT = START_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   wrEn,
    input  logic [7:0]             wrData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   txStart,
    output logic [7:0]             txIn,
    input  logic                   txBusy,
    input  logic                   txDone,
    output logic                   timeoutErr,
    output logic [15:0]            sentCount
);

    localparam int TW = $clog2(START_TIMEOUT + 1);

    feeder_state_e state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_in_q, tx_in_d;
    logic          timeout_err_q, timeout_err_d;
    logic [15:0]   sent_count_q, sent_count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pop_s;
    logic [7:0]    head_s;
    logic          empty_s;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wrEn),
        .wr_data  (wrData),
        .rd_en    (pop_s),
        .rd_data  (head_s),
        .full     (full),
        .empty    (empty_s),
        .count    (count),
        .overflow (overflow)
    );

    // Feeder FSM next-state; a pop only ever happens from IDLE, giving at least one IDLE cycle per byte.
    always_comb begin
        state_d       = state_q;
        tx_start_d    = tx_start_q;
        tx_in_d       = tx_in_q;
        sent_count_d  = sent_count_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;
        pop_s         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !empty_s) begin
                    pop_s      = 1'b1;
                    tx_in_d    = head_s;
                    tx_start_d = 1'b1;
                    timer_d    = {TW{1'b0}};
                    state_d    = ST_START;
                end else begin
                    tx_start_d = 1'b0;
                end
            end
            ST_START: begin
                if (txBusy) begin
                    tx_start_d   = 1'b0;
                    sent_count_d = sent_count_q + 16'd1;
                    state_d      = ST_WAIT_DONE;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    tx_start_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (txDone || !txBusy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Feeder FSM and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            tx_start_q    <= 1'b0;
            tx_in_q       <= 8'h00;
            timeout_err_q <= 1'b0;
            sent_count_q  <= 16'h0000;
            timer_q       <= {TW{1'b0}};
        end else begin
            state_q       <= state_d;
            tx_start_q    <= tx_start_d;
            tx_in_q       <= tx_in_d;
            timeout_err_q <= timeout_err_d;
            sent_count_q  <= sent_count_d;
            timer_q       <= timer_d;
        end
    end

    assign empty      = empty_s;
    assign txStart    = tx_start_q;
    assign txIn       = tx_in_q;
    assign timeoutErr = timeout_err_q;
    assign sentCount  = sent_count_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder with a behavioural UART responder and queue-based reference model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, en, wrEn;
    logic [7:0]    wrData;
    logic          full, empty, overflow, txStart, txBusy, txDone, timeoutErr;
    logic [CW-1:0] count;
    logic [7:0]    txIn;
    logic [15:0]   sentCount;

    int n_checks = 0;
    int n_errors = 0;

    // Responder state: a UART that answers txStart with busy, then done.
    bit         uart_en;
    int         phase, cnt;
    logic [7:0] rx_q[$];

    // Reference model state.
    logic [7:0] exp_q[$];
    int         sent_model;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH         (DEPTH),
        .START_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wrEn       (wrEn),
        .wrData     (wrData),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .txStart    (txStart),
        .txIn       (txIn),
        .txBusy     (txBusy),
        .txDone     (txDone),
        .timeoutErr (timeoutErr),
        .sentCount  (sentCount)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wrEn   = 1'b1;
        wrData = d;
        step();
        wrEn   = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            step();
            if (empty && !txStart && !txBusy && phase == 0) ok = 1'b1;
        end
        step();
        step();
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
    endtask

    // Behavioural UART: random start latency, random frame length, done pulse at frame end.
    initial begin
        txBusy = 1'b0;
        txDone = 1'b0;
        phase  = 0;
        cnt    = 0;
        forever begin
            @(posedge clk);
            #2;
            txDone = 1'b0;
            case (phase)
                0: if (txStart && uart_en) begin
                       cnt   = $urandom_range(0, 3);
                       phase = 1;
                   end
                1: if (cnt == 0) begin
                       txBusy = 1'b1;
                       rx_q.push_back(txIn);
                       cnt    = $urandom_range(4, 12);
                       phase  = 2;
                   end else begin
                       cnt--;
                   end
                2: if (cnt == 0) begin
                       txBusy = 1'b0;
                       txDone = 1'b1;
                       phase  = 0;
                   end else begin
                       cnt--;
                   end
                default: phase = 0;
            endcase
        end
    end

    initial begin
        bit ovf_seen, started, ok, wr, exp_ovf;
        logic [7:0] d;
        int ncyc;

        rst = 1'b1; en = 1'b0; wrEn = 1'b0; wrData = 8'h00; uart_en = 1'b1;
        sent_model = 0;
        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_txstart", 32'(txStart), 32'd0);
        check("rst_txin", 32'(txIn), 32'd0);
        check("rst_sent", 32'(sentCount), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_tmo", 32'(timeoutErr), 32'd0);
        rst = 1'b0;
        step();

        // Single byte with latency check.
        en = 1'b1;
        rx_q.delete(); exp_q = '{8'h8A};
        write_byte(8'h8A);
        check("single_cnt", 32'(count), 32'd1);
        check("single_start_early", 32'(txStart), 32'd0);
        step();
        check("single_start", 32'(txStart), 32'd1);
        check("single_txin", 32'(txIn), 32'h8A);
        wait_drain("single_drain");
        check_rx("single_rx");
        sent_model += 1;
        check("single_sent", 32'(sentCount), 32'(sent_model));
        check("single_empty", 32'(empty), 32'd1);

        // Back-to-back burst.
        rx_q.delete(); exp_q.delete(); ovf_seen = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            write_byte(8'(i));
            exp_q.push_back(8'(i));
            ovf_seen |= overflow;
        end
        wait_drain("burst_drain");
        check("burst_ovf", 32'(ovf_seen), 32'd0);
        check_rx("burst_rx");
        check("burst_count", 32'(count), 32'd0);
        sent_model += 5;
        check("burst_sent", 32'(sentCount), 32'(sent_model));

        // Fill to full with the drain disabled; the fifth byte is dropped.
        en = 1'b0; rx_q.delete(); exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            write_byte(8'hA0 + 8'(i));
            if (i < DEPTH) exp_q.push_back(8'hA0 + 8'(i));
            check($sformatf("fill_ovf%0d", i), 32'(overflow), 32'(i == 4));
            check($sformatf("fill_full%0d", i), 32'(full), 32'(i >= DEPTH - 1));
            check($sformatf("fill_cnt%0d", i), 32'(count), 32'(exp_q.size()));
        end
        step();
        check("fill_ovf_pulse", 32'(overflow), 32'd0);
        en = 1'b1;
        wait_drain("fill_drain");
        check_rx("fill_rx");
        sent_model += DEPTH;
        check("fill_sent", 32'(sentCount), 32'(sent_model));

        // Random fill rounds checked cycle by cycle against a queue model.
        for (int r = 0; r < 6; r++) begin
            en = 1'b0; rx_q.delete(); exp_q.delete();
            ncyc = $urandom_range(3, 9);
            for (int c = 0; c < ncyc; c++) begin
                wr      = ($urandom_range(0, 3) != 0);
                d       = 8'($urandom);
                exp_ovf = wr && (exp_q.size() == DEPTH);
                if (wr && exp_q.size() < DEPTH) exp_q.push_back(d);
                wrEn = wr; wrData = d;
                step();
                wrEn = 1'b0;
                check("rnd_cnt", 32'(count), 32'(exp_q.size()));
                check("rnd_full", 32'(full), 32'(exp_q.size() == DEPTH));
                check("rnd_empty", 32'(empty), 32'(exp_q.size() == 0));
                check("rnd_ovf", 32'(overflow), 32'(exp_ovf));
            end
            en = 1'b1;
            wait_drain("rnd_drain");
            check_rx("rnd_rx");
            sent_model += exp_q.size();
            check("rnd_sent", 32'(sentCount), 32'(sent_model));
        end

        // Start timeout with the UART refusing to go busy.
        uart_en = 1'b0; rx_q.delete();
        write_byte(8'h55);
        step();
        check("tmo_start", 32'(txStart), 32'd1);
        for (int k = 1; k <= TO; k++) begin
            step();
            check($sformatf("tmo_err%0d", k), 32'(timeoutErr), 32'(k == TO));
            check($sformatf("tmo_txs%0d", k), 32'(txStart), 32'(k != TO));
        end
        step();
        check("tmo_pulse", 32'(timeoutErr), 32'd0);
        check("tmo_sent", 32'(sentCount), 32'(sent_model));
        check("tmo_empty", 32'(empty), 32'd1);
        check("tmo_rx", 32'(rx_q.size()), 32'd0);
        uart_en = 1'b1;
        step();

        // Dropping en during a frame lets it finish but holds the next byte.
        rx_q.delete(); exp_q = '{8'h3C};
        write_byte(8'h3C);
        write_byte(8'hC3);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (txBusy) ok = 1'b1; else step();
        end
        check("entog_busy", 32'(ok), 32'd1);
        en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            if (!txBusy && phase == 0) ok = 1'b1;
        end
        check("entog_done", 32'(ok), 32'd1);
        started = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            started |= txStart;
        end
        check("entog_hold", 32'(started), 32'd0);
        check("entog_cnt", 32'(count), 32'd1);
        check_rx("entog_rx1");
        en = 1'b1;
        exp_q.push_back(8'hC3);
        wait_drain("entog_drain");
        check_rx("entog_rx2");
        sent_model += 2;
        check("entog_sent", 32'(sentCount), 32'(sent_model));

        // Reset while a frame is in flight.
        rx_q.delete(); exp_q = '{8'h11};
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (txBusy) ok = 1'b1; else step();
        end
        check("rstmid_busy", 32'(ok), 32'd1);
        step();
        rst = 1'b1;
        step();
        check("rstmid_cnt", 32'(count), 32'd0);
        check("rstmid_txs", 32'(txStart), 32'd0);
        check("rstmid_sent", 32'(sentCount), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        rst = 1'b0;
        started = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            started |= txStart;
        end
        check("rstmid_nostart", 32'(started), 32'd0);
        check("rstmid_cnt2", 32'(count), 32'd0);
        check_rx("rstmid_rx");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
